sr_latch_driver: RTL and testbench

Clocked driver end of the SR-latch interface. It accepts set/reset commands over a valid/ready handshake and emits clean, timed set/reset pulses to an SR latch. A guard interval separates pulses, and s_o/r_o are never high together. It keeps a shadow of the commanded latch state so a synchronous domain can steer an asynchronous latch without ever producing the forbidden S=R=1 condition.

---
 rtl/sr_latch_pkg.sv | 24 ++
 rtl/sr_pulse_timer.sv | 26 ++
 rtl/sr_latch_driver.sv | 143 ++++++++++++++
 tb/tb_sr_latch_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and helpers for the SR-latch driver slice.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2
    } sr_drv_state_e;

    typedef enum logic {
        SR_CMD_RESET = 1'b0,
        SR_CMD_SET   = 1'b1
    } sr_cmd_e;

    // Counter must hold max(pulse, guard) - 1; never narrower than one bit.
    function automatic int cnt_width(input int pulse_cycles, input int guard_cycles);
        int m;
        int w;
        m = (pulse_cycles > guard_cycles) ? pulse_cycles : guard_cycles;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module sr_pulse_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero_o = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked SR-latch pulse driver with guard interval and shadow state.
// Optional latch readback check enabled by defining SR_DRIVER_READBACK_EN.
module sr_latch_driver
    import sr_latch_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 1
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic req_valid_i,
    input  logic req_set_i,
    output logic req_ready_o,
    output logic s_o,
    output logic r_o,
    output logic state_o,
    output logic busy_o,
`ifdef SR_DRIVER_READBACK_EN
    input  logic q_i,
    output logic mismatch_o,
`endif
    output logic done_o
);

    localparam int CW = cnt_width(PULSE_CYCLES, GUARD_CYCLES);
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = HAS_GUARD ? CW'(GUARD_CYCLES - 1) : '0;

    if (PULSE_CYCLES < 1 || GUARD_CYCLES < 0) begin : g_bad_params
        $error("sr_latch_driver: PULSE_CYCLES must be >= 1 and GUARD_CYCLES >= 0");
    end

    sr_drv_state_e   state;
    sr_cmd_e         cmd;
    logic            accept;
    logic            start;
    logic            zero;
    logic            load;
    logic [CW-1:0]   load_val;

    assign req_ready_o = (state == IDLE);
    assign cmd         = sr_cmd_e'(req_set_i);
    assign accept      = req_valid_i && (state == IDLE);
    assign start       = accept && (req_set_i != state_o);

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (start) begin
            load     = 1'b1;
            load_val = PULSE_LOAD;
        end else if (state == PULSE && zero && HAS_GUARD) begin
            load     = 1'b1;
            load_val = GUARD_LOAD;
        end
    end

    sr_pulse_timer #(
        .WIDTH(CW)
    ) u_timer (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .load_i    (load),
        .load_val_i(load_val),
        .zero_o    (zero)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state   <= IDLE;
            s_o     <= 1'b0;
            r_o     <= 1'b0;
            state_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= PULSE;
                        busy_o  <= 1'b1;
                        s_o     <= (cmd == SR_CMD_SET);
                        r_o     <= (cmd == SR_CMD_RESET);
                        state_o <= req_set_i;
                    end else if (accept) begin
                        // Redundant command: acknowledge without touching the latch.
                        done_o <= 1'b1;
                    end
                end
                PULSE: begin
                    if (zero) begin
                        s_o <= 1'b0;
                        r_o <= 1'b0;
                        if (HAS_GUARD) begin
                            state <= GUARD;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                GUARD: begin
                    if (zero) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    s_o    <= 1'b0;
                    r_o    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRIVER_READBACK_EN
    logic q_meta;
    logic q_sync;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            q_meta     <= 1'b0;
            q_sync     <= 1'b0;
            mismatch_o <= 1'b0;
        end else begin
            q_meta <= q_i;
            q_sync <= q_meta;
            if (done_o && (q_sync != state_o)) begin
                mismatch_o <= 1'b1;
            end else if (accept) begin
                mismatch_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench: two driver configurations against a schedule-queue model.
module tb_sr_latch_driver;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    logic valid  = 1'b0;
    logic set    = 1'b0;

    logic s_w[2];
    logic r_w[2];
    logic st_w[2];
    logic busy_w[2];
    logic done_w[2];
    logic rdy_w[2];
`ifdef SR_DRIVER_READBACK_EN
    logic q = 1'b0;
    logic mis_w[2];
`endif

    always #5 clk = ~clk;

    sr_latch_driver #(
        .PULSE_CYCLES(2),
        .GUARD_CYCLES(1)
    ) dut (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .req_valid_i(valid),
        .req_set_i  (set),
        .req_ready_o(rdy_w[0]),
        .s_o        (s_w[0]),
        .r_o        (r_w[0]),
        .state_o    (st_w[0]),
        .busy_o     (busy_w[0]),
`ifdef SR_DRIVER_READBACK_EN
        .q_i        (q),
        .mismatch_o (mis_w[0]),
`endif
        .done_o     (done_w[0])
    );

    sr_latch_driver #(
        .PULSE_CYCLES(3),
        .GUARD_CYCLES(0)
    ) dut3 (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .req_valid_i(valid),
        .req_set_i  (set),
        .req_ready_o(rdy_w[1]),
        .s_o        (s_w[1]),
        .r_o        (r_w[1]),
        .state_o    (st_w[1]),
        .busy_o     (busy_w[1]),
`ifdef SR_DRIVER_READBACK_EN
        .q_i        (q),
        .mismatch_o (mis_w[1]),
`endif
        .done_o     (done_w[1])
    );

    // One planned output record per future cycle.
    typedef struct packed {
        logic s;
        logic r;
        logic busy;
        logic done;
    } rec_t;

    rec_t sched[2][$];
    rec_t cur[2];
    logic mst[2];
    logic mmis[2];
    int   pc[2] = '{2, 3};
    int   gc[2] = '{1, 0};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sched[k].delete();
            cur[k]  = '0;
            mst[k]  = 1'b0;
            mmis[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic acc;
        rec_t rec;
        if (!arst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc = valid && !cur[k].busy;
`ifdef SR_DRIVER_READBACK_EN
                if (cur[k].done && (mst[k] != q)) mmis[k] = 1'b1;
                else if (acc) mmis[k] = 1'b0;
`endif
                if (acc) begin
                    if (set != mst[k]) begin
                        for (int i = 0; i < pc[k]; i++) begin
                            rec = '{s: set, r: !set, busy: 1'b1, done: 1'b0};
                            sched[k].push_back(rec);
                        end
                        for (int i = 0; i < gc[k]; i++) begin
                            rec = '{s: 1'b0, r: 1'b0, busy: 1'b1, done: 1'b0};
                            sched[k].push_back(rec);
                        end
                        mst[k] = set;
                    end
                    rec = '{s: 1'b0, r: 1'b0, busy: 1'b0, done: 1'b1};
                    sched[k].push_back(rec);
                end
                cur[k] = (sched[k].size() > 0) ? sched[k].pop_front() : '0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("outs_dut%0d", k),
                {2'b00, s_w[k], r_w[k], busy_w[k], done_w[k], st_w[k], rdy_w[k]},
                {2'b00, cur[k].s, cur[k].r, cur[k].busy, cur[k].done, mst[k], !cur[k].busy});
            chk($sformatf("s_and_r_dut%0d", k), {7'd0, s_w[k] && r_w[k]}, 8'd0);
`ifdef SR_DRIVER_READBACK_EN
            chk($sformatf("mismatch_dut%0d", k), {7'd0, mis_w[k]}, {7'd0, mmis[k]});
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        logic       v;
        logic       st;
        logic [4:0] exp;   // {s, r, state, busy, done} of the default-config DUT
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 5'b10110};
        vecs[1]  = '{1'b0, 1'b0, 5'b10110};
        vecs[2]  = '{1'b0, 1'b0, 5'b00110};
        vecs[3]  = '{1'b0, 1'b0, 5'b00101};
        vecs[4]  = '{1'b1, 1'b1, 5'b00101};
        vecs[5]  = '{1'b0, 1'b0, 5'b00100};
        vecs[6]  = '{1'b1, 1'b0, 5'b01010};
        vecs[7]  = '{1'b1, 1'b1, 5'b01010};
        vecs[8]  = '{1'b1, 1'b1, 5'b00010};
        vecs[9]  = '{1'b0, 1'b0, 5'b00001};
        vecs[10] = '{1'b0, 1'b0, 5'b00000};

        model_reset();
        #1 arst_n = 1'b0;
        #1 check_all();
        repeat (2) step();
        #2 arst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            valid = vecs[i].v;
            set   = vecs[i].st;
            step();
            chk($sformatf("vec%0d", i),
                {3'b000, s_w[0], r_w[0], st_w[0], busy_w[0], done_w[0]},
                {3'b000, vecs[i].exp});
        end

        valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set = i[0];
            step();
        end
        valid = 1'b0;
        repeat (6) step();

        // Async reset in the first cycle of a pulse on the default DUT.
        set   = !mst[0];
        valid = 1'b1;
        step();
        valid = 1'b0;
        chk("pulse_started", {7'd0, s_w[0] || r_w[0]}, 8'd1);
        #2 arst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_reset_dut%0d", k),
                {3'b000, s_w[k], r_w[k], st_w[k], busy_w[k], done_w[k]}, 8'd0);
        end
        step();
        #2 arst_n = 1'b1;
        valid = 1'b1;
        set   = 1'b1;
        step();
        valid = 1'b0;
        chk("post_reset_set", {6'd0, s_w[0], r_w[0]}, 8'b10);
        repeat (6) step();

        for (int i = 0; i < 400; i++) begin
            valid = ($urandom % 3) != 0;
            set   = $urandom % 2;
            step();
        end
        valid = 1'b0;
        repeat (6) step();

`ifdef SR_DRIVER_READBACK_EN
        valid = 1'b1; set = 1'b0; step(); valid = 1'b0;
        repeat (6) step();
        valid = 1'b1; set = 1'b1; step(); valid = 1'b0;
        repeat (6) step();
        chk("readback_mismatch_set", {7'd0, mis_w[0]}, 8'd1);
        valid = 1'b1; set = 1'b0; step(); valid = 1'b0;
        repeat (6) step();
        chk("readback_mismatch_clear", {7'd0, mis_w[0]}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
